// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Masks are built at 32 bits, so MAX_LEN is limited to 32.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

  localparam int unsigned MASK_W = 32;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_history.sv
// Bit history shift register, fill counter and masked pattern compare.
// o_match is combinational and reflects the bit being accepted this cycle.
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic               i_overlap,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match,
  output logic               o_full
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_next;

  assign w_hist_next = MAX_LEN'({r_hist, i_bit});
  assign w_fill_next = (r_fill >= i_len) ? i_len : r_fill + 1'b1;
  assign w_mask      = MAX_LEN'(len_mask(32'(i_len)));
  assign o_full      = (w_fill_next == i_len);
  assign o_match     = i_shift && o_full &&
                       (((w_hist_next ^ i_pattern) & w_mask) == '0);

  // Non-overlapping hits restart the fill so the next hit needs len fresh bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_next;
      r_fill <= (o_match && !i_overlap) ? '0 : w_fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-sequence detector with pulse/sticky output.
// Optional match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_sticky,
  input  logic               det_clr,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               Out1,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   match_cnt
);

  state_e             r_state, w_state_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_sticky;
  logic               r_out1, w_out1_next;
  logic               w_len_ok, w_shift, w_clear, w_match, w_full;

  assign w_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_shift  = !cfg_load && in_valid && ((r_state == ST_FILL) || (r_state == ST_ARMED));
  assign w_clear  = cfg_load || ((r_state == ST_HOLD) && det_clr);

  seq_det_history #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_history (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_clear   (w_clear),
    .i_shift   (w_shift),
    .i_bit     (in_bit),
    .i_overlap (r_overlap),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_match   (w_match),
    .o_full    (w_full)
  );

  always_comb begin
    w_state_next = r_state;
    w_out1_next  = 1'b0;
    if (cfg_load) begin
      w_state_next = w_len_ok ? ST_FILL : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_FILL, ST_ARMED: begin
          if (w_shift) begin
            if (w_match) begin
              w_out1_next = 1'b1;
              if (r_sticky)       w_state_next = ST_HOLD;
              else if (r_overlap) w_state_next = ST_ARMED;
              else                w_state_next = ST_FILL;
            end else begin
              w_state_next = w_full ? ST_ARMED : ST_FILL;
            end
          end
        end
        ST_HOLD: begin
          if (det_clr) w_state_next = ST_FILL;
          else         w_out1_next  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_sticky  <= 1'b0;
      r_out1    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out1  <= w_out1_next;
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_sticky  <= cfg_sticky;
      end
    end
  end

  assign Out1    = r_out1;
  assign state_o = r_state;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST || cfg_load) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: queue-based reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;

`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cfg_sticky = 1'b0;
  logic               det_clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               Out1;
  logic [1:0]         state_o;
  logic [CNT_W-1:0]   match_cnt;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_sticky  (cfg_sticky),
    .det_clr     (det_clr),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .Out1        (Out1),
    .state_o     (state_o),
    .match_cnt   (match_cnt)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: what the outputs must be after the coming edge
  bit               m_cfg, m_hold, m_ov, m_st, m_out;
  int               m_len, m_since, m_cnt;
  logic [MAX_LEN-1:0] m_pat;
  bit               m_q[$];

  logic       c_out;
  logic [1:0] c_state;
  logic [CNT_W-1:0] c_cnt;

  function automatic bit tail_match();
    for (int k = 0; k < m_len; k++)
      if (m_q[m_q.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_state();
    if (!m_cfg) return 2'd0;
    if (m_hold) return 2'd3;
    if (m_since >= m_len) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
    return CNT_ON ? CNT_W'(m_cnt) : '0;
  endfunction

  task automatic model_update();
    bit hit;
    if (!RST) begin
      m_cfg = 0; m_hold = 0; m_ov = 0; m_st = 0; m_out = 0;
      m_len = 0; m_since = 0; m_cnt = 0; m_pat = '0; m_q.delete();
    end else if (cfg_load) begin
      m_len = int'(cfg_len); m_pat = cfg_pattern; m_ov = cfg_overlap; m_st = cfg_sticky;
      m_cfg = (m_len >= 1) && (m_len <= MAX_LEN);
      m_hold = 0; m_since = 0; m_out = 0; m_cnt = 0; m_q.delete();
    end else if (!m_cfg) begin
      m_out = 0;
    end else if (m_hold) begin
      if (det_clr) begin
        m_hold = 0; m_since = 0; m_out = 0; m_q.delete();
      end else begin
        m_out = 1;
      end
    end else if (in_valid) begin
      m_q.push_back(in_bit);
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      m_since++;
      hit = (m_since >= m_len) && tail_match();
      m_out = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_st) m_hold = 1;
        else if (!m_ov) m_since = 0;
      end
    end else begin
      m_out = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_out1", 32'(Out1), 32'(m_out));
      check("cyc_state", 32'(state_o), 32'(exp_state()));
      check("cyc_cnt", 32'(match_cnt), 32'(exp_cnt()));
    end
  end

  // One clock per call; captures the DUT outputs produced by these inputs.
  task automatic step(input bit rst_n, input bit ld, input bit clr, input bit v, input bit b);
    RST = rst_n; cfg_load = ld; det_clr = clr; in_valid = v; in_bit = b;
    model_update();
    @(posedge CLK); #1;
    c_out = Out1; c_state = state_o; c_cnt = match_cnt;
    @(negedge CLK); #1;
  endtask

  task automatic load(input int len, input logic [MAX_LEN-1:0] pat, input bit ov, input bit st);
    cfg_len = LEN_W'(len); cfg_pattern = pat; cfg_overlap = ov; cfg_sticky = st;
    step(1, 1, 0, 0, 0);
  endtask

  // bits are sent MSB-first; pulses[i] is Out1 after bit i, gap_hi counts Out1 highs in idle gaps
  task automatic send(input logic [15:0] bits, input int n, input int gap,
                      output logic [15:0] pulses, output int gap_hi);
    pulses = '0; gap_hi = 0;
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 1, bits[n - 1 - i]);
      pulses[i] = c_out;
      for (int g = 0; g < gap; g++) begin
        step(1, 0, 0, 0, 0);
        if (c_out) gap_hi++;
      end
    end
  endtask

  logic [15:0] p;
  int gh;

  initial begin
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_out1", 32'(c_out), 0);
    check("rst_state", 32'(c_state), 0);
    send(16'b101, 3, 0, p, gh);
    check("idle_ignores", 32'(p), 0);

    // 1: sticky len=2 pattern 10
    load(2, 8'b10, 0, 1);
    send(16'b10, 2, 0, p, gh);
    check("t1_hit", 32'(p), 32'b10);
    check("t1_hold_state", 32'(c_state), 3);
    send(16'b11010, 5, 0, p, gh);
    check("t1_held", 32'(p), 32'b11111);
    step(1, 0, 1, 0, 0);
    check("t1_clr_out1", 32'(c_out), 0);
    check("t1_clr_state", 32'(c_state), 1);

    // 2: overlap pulse len=3 pattern 101
    load(3, 8'b101, 1, 0);
    send(16'b10101, 5, 0, p, gh);
    check("t2_pulses", 32'(p), 32'b10100);
    check("t2_cnt", 32'(c_cnt), CNT_ON ? 2 : 0);

    // 3: non-overlap
    load(3, 8'b101, 0, 0);
    send(16'b10101, 5, 0, p, gh);
    check("t3a_pulses", 32'(p), 32'b00100);
    load(3, 8'b101, 0, 0);
    send(16'b10101101, 8, 0, p, gh);
    check("t3b_pulses", 32'(p), 32'h84);

    // 4: overlap with 2-cycle valid gaps
    load(3, 8'b101, 1, 0);
    send(16'b10101, 5, 2, p, gh);
    check("t4_pulses", 32'(p), 32'b10100);
    check("t4_gap_low", 32'(gh), 0);

    // 5: cfg_load with in_valid mid-pattern, then invalid lengths
    load(3, 8'b101, 1, 0);
    send(16'b10, 2, 0, p, gh);
    step(1, 1, 0, 1, 1);
    check("t5_ld_out1", 32'(c_out), 0);
    check("t5_ld_state", 32'(c_state), 1);
    send(16'b01, 2, 0, p, gh);
    check("t5_no_hit", 32'(p), 0);
    check("t5_fill_state", 32'(c_state), 1);
    load(0, 8'b1, 1, 0);
    check("t5_len0_idle", 32'(c_state), 0);
    send(16'b111, 3, 0, p, gh);
    check("t5_len0_nohit", 32'(p), 0);
    load(9, 8'b1, 1, 0);
    check("t5_len9_idle", 32'(c_state), 0);

    // full-length pattern
    load(8, 8'hA5, 1, 0);
    send(16'hA5, 8, 0, p, gh);
    check("len8_pulse", 32'(p), 32'h80);
    check("len8_state", 32'(c_state), 2);

    // 6: reset while HOLD, then saturation with len=1
    load(2, 8'b10, 0, 1);
    send(16'b10, 2, 0, p, gh);
    step(0, 0, 0, 0, 0);
    check("t6_rst_out1", 32'(c_out), 0);
    check("t6_rst_state", 32'(c_state), 0);
    check("t6_rst_cnt", 32'(c_cnt), 0);
    load(1, 8'b1, 0, 0);
    send(16'b111011, 6, 0, p, gh);
    check("t6_len1_pulses", 32'(p), 32'b110111);
    check("t6_sat_cnt", 32'(c_cnt), CNT_ON ? 3 : 0);
    step(1, 0, 1, 1, 1);
    check("t6_clr_nohold", 32'(c_out), 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
